dmem_dma: RTL and testbench

DMEM_DMA -- requirements
Module: dmem_dma

---
 rtl/dmem_dma_pkg.sv | 7 +
 rtl/dmem_dma.sv | 79 +++++++
 tb/tb_dmem_dma.sv | 142 ++++++++++++++
 3 files changed

// File: rtl/dmem_dma_pkg.sv
// dmem_dma_pkg: shared defaults and FSM state type for the dmem_dma block
package dmem_dma_pkg;
    localparam int DMEM_DATA_W = 32;
    localparam int DMEM_DEPTH  = 32;
    localparam int DMEM_ADDR_W = 5;
    typedef enum logic [2:0] {IDLE, READ, WRITE, DONE, ERR} state_t;
endpackage

// File: rtl/dmem_dma.sv
// dmem_dma: word copy/fill DMA engine mastering a data memory with combinational reads
//   clk, rst_n (async, active-low)
//   start/mode/src_addr/dst_addr/len/fill_value : transfer request, latched in IDLE
//   busy/done/err                               : status (done, err are one-cycle pulses)
//   mem_read/mem_write/mem_address/mem_write_data/mem_read_data : memory master port
module dmem_dma import dmem_dma_pkg::*; #(
    parameter int DATA_W = DMEM_DATA_W,
    parameter int DEPTH  = DMEM_DEPTH,
    parameter int ADDR_W = DMEM_ADDR_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              mode,
    input  logic [ADDR_W-1:0] src_addr,
    input  logic [ADDR_W-1:0] dst_addr,
    input  logic [ADDR_W:0]   len,
    input  logic [DATA_W-1:0] fill_value,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic              mem_read,
    output logic              mem_write,
    output logic [31:0]       mem_address,
    output logic [DATA_W-1:0] mem_write_data,
    input  logic [DATA_W-1:0] mem_read_data
);
    state_t            state;
    logic [ADDR_W-1:0] src, dst;
    logic [ADDR_W:0]   n, i;
    logic              md;
    logic [DATA_W-1:0] fill, data;
    logic [31:0]       rd_a, wr_a;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            src   <= '0;
            dst   <= '0;
            n     <= '0;
            i     <= '0;
            md    <= 1'b0;
            fill  <= '0;
            data  <= '0;
        end else begin
            case (state)
                IDLE: if (start) begin
                    src   <= src_addr;
                    dst   <= dst_addr;
                    n     <= len;
                    md    <= mode;
                    fill  <= fill_value;
                    i     <= '0;
                    state <= 32'(len) > $unsigned(DEPTH) ? ERR : len == '0 ? DONE : mode ? WRITE : READ;
                end
                READ: begin
                    data  <= mem_read_data;
                    state <= WRITE;
                end
                WRITE: begin
                    i     <= i + 1'b1;
                    state <= i + 1'b1 == n ? DONE : md ? WRITE : READ;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // addresses wrap modulo DEPTH, which need not be a power of two
    assign rd_a           = (32'(src) + 32'(i)) % $unsigned(DEPTH);
    assign wr_a           = (32'(dst) + 32'(i)) % $unsigned(DEPTH);
    assign mem_read       = state == READ;
    assign mem_write      = state == WRITE;
    assign busy           = mem_read | mem_write;
    assign done           = state == DONE;
    assign err            = state == ERR;
    assign mem_address    = mem_read ? rd_a : mem_write ? wr_a : '0;
    assign mem_write_data = mem_write ? (md ? fill : data) : '0;
endmodule

// File: tb/tb_dmem_dma.sv
// tb_dmem_dma: scoreboard bench for dmem_dma against a behavioural memory and reference copy
module tb_dmem_dma;
    typedef struct {logic [31:0] a; logic [31:0] d; int c;} wr_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        mode = 1'b0;
    logic [4:0]  src_addr = '0, dst_addr = '0;
    logic [5:0]  len = '0;
    logic [31:0] fill_value = '0;
    logic        busy, done, err, mem_read, mem_write;
    logic [31:0] mem_address, mem_write_data, mem_read_data;
    logic [31:0] mem [32];
    logic [31:0] ref_mem [32];
    wr_t         exp_q [$];
    int          n_run = 0, n_fail = 0;

    dmem_dma dut (
        .clk(clk), .rst_n(rst_n), .start(start), .mode(mode),
        .src_addr(src_addr), .dst_addr(dst_addr), .len(len), .fill_value(fill_value),
        .busy(busy), .done(done), .err(err),
        .mem_read(mem_read), .mem_write(mem_write), .mem_address(mem_address),
        .mem_write_data(mem_write_data), .mem_read_data(mem_read_data)
    );

    always #5 clk = ~clk;

    assign mem_read_data = mem[mem_address[4:0]];

    always @(posedge clk) if (mem_write) mem[mem_address[4:0]] = mem_write_data;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_run++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic xfer(input logic m, input int s, input int d, input int l, input logic [31:0] f,
                        input int exp_done, input int exp_err, input bit poke);
        int done_c = 0, err_c = 0;
        wr_t w;
        for (int k = 0; k < l && l <= 32; k++) begin
            w.a = (d + k) % 32;
            w.d = m ? f : ref_mem[(s + k) % 32];
            w.c = m ? k + 1 : 2 * k + 2;
            ref_mem[w.a] = w.d;
            exp_q.push_back(w);
        end
        @(negedge clk);
        start = 1'b1; mode = m; src_addr = s[4:0]; dst_addr = d[4:0]; len = l[5:0]; fill_value = f;
        @(posedge clk);
        #1;
        start = 1'b0; mode = ~m; src_addr = 5'($urandom); dst_addr = 5'($urandom);
        len = 6'($urandom); fill_value = $urandom;
        for (int k = 1; k <= 200; k++) begin
            @(negedge clk);
            chk("rd_wr_excl", mem_read & mem_write, 0);
            chk("busy", busy, mem_read | mem_write);
            if (m) chk("fill_no_read", mem_read, 0);
            if (mem_write) begin
                chk("wr_expected", exp_q.size() != 0, 1);
                if (exp_q.size() != 0) begin
                    w = exp_q.pop_front();
                    chk("wr_addr", mem_address, w.a);
                    chk("wr_data", mem_write_data, w.d);
                    chk("wr_cycle", k, w.c);
                end
            end
            if (done && done_c == 0) done_c = k;
            if (err && err_c == 0) err_c = k;
            start = poke && k == 3;
            if (done || err) break;
        end
        start = 1'b0;
        chk("done_cycle", done_c, exp_done);
        chk("err_cycle", err_c, exp_err);
        chk("scoreboard_empty", exp_q.size(), 0);
        exp_q.delete();
        repeat (3) begin
            @(negedge clk);
            chk("idle_quiet", {done, err, mem_read, mem_write, busy}, 0);
        end
    endtask

    initial begin
        logic [31:0] keep [6];
        for (int k = 0; k < 32; k++) begin
            mem[k] = 32'h40600000 + (k - 1) * 32'h00466666;
            ref_mem[k] = mem[k];
        end
        #3;
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_err", err, 0);
        chk("rst_rd_wr", {mem_read, mem_write}, 0);
        chk("rst_addr", mem_address, 0);
        chk("rst_wdata", mem_write_data, 0);
        @(negedge clk);
        rst_n = 1'b1;

        xfer(1'b0, 1, 16, 6, 32'h0, 13, 0, 1'b0);
        for (int k = 0; k < 6; k++) chk("copy_word", mem[16 + k], mem[1 + k]);
        xfer(1'b1, 0, 30, 4, 32'h3F800000, 5, 0, 1'b0);
        xfer(1'b0, 3, 7, 0, 32'h0, 1, 0, 1'b0);
        xfer(1'b0, 3, 7, 40, 32'h0, 0, 1, 1'b0);
        xfer(1'b0, 0, 8, 3, 32'h0, 7, 0, 1'b1);
        xfer(1'b0, 2, 4, 5, 32'h0, 11, 0, 1'b0);
        for (int k = 0; k < 32; k++) chk("mem_model", mem[k], ref_mem[k]);

        for (int k = 0; k < 6; k++) keep[k] = mem[24 + k];
        @(negedge clk);
        start = 1'b1; mode = 1'b0; src_addr = 5'd0; dst_addr = 5'd24; len = 6'd6;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (5) @(negedge clk);
        chk("pre_rst_busy", busy, 1);
        #1 rst_n = 1'b0;
        #1;
        chk("abort_write", mem_write, 0);
        chk("abort_read", mem_read, 0);
        chk("abort_busy", busy, 0);
        chk("abort_addr", mem_address, 0);
        repeat (3) begin
            @(negedge clk);
            chk("abort_no_done", {done, err, mem_write}, 0);
        end
        rst_n = 1'b1;
        repeat (4) begin
            @(negedge clk);
            chk("post_rst_quiet", {done, err, mem_read, mem_write}, 0);
        end
        chk("abort_w0", mem[24], ref_mem[0]);
        chk("abort_w1", mem[25], ref_mem[1]);
        for (int k = 2; k < 6; k++) chk("abort_untouched", mem[24 + k], keep[k]);

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end
endmodule
